// File: rtl/alu_op_issuer_pkg.sv
// alu_pkg: ALU opcode type, opcode constants and legality check for the issuer
package alu_pkg;
  typedef logic [4:0] alu_op_t;
  localparam alu_op_t OP_ADD = 5'd0;
  localparam alu_op_t OP_SUB = 5'd1;
  localparam alu_op_t OP_SLL = 5'd2;
  localparam alu_op_t OP_SRA = 5'd3;
  localparam alu_op_t OP_AND = 5'd4;
  localparam alu_op_t OP_OR = 5'd5;
  localparam alu_op_t OP_XOR = 5'd6;
  localparam alu_op_t OP_EQL = 5'd7;
  localparam alu_op_t OP_LESSEQL = 5'd8;
  localparam alu_op_t OP_GREQL = 5'd9;
  localparam alu_op_t OP_NEQL = 5'd10;
  localparam alu_op_t OP_JAL_JALR = 5'd31;
  function automatic logic is_legal_op(alu_op_t op);
    return op <= OP_NEQL || op == OP_JAL_JALR;
  endfunction
endpackage

// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: request, ALU and response signals of the ALU op issuer
interface alu_op_issuer_if #(parameter int TAG_W = 4);
  import alu_pkg::*;
  logic req_valid_i;
  logic req_ready_o;
  alu_op_t req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  alu_op_t alu_op_o;
  logic [31:0] alu_res_i;
  logic rsp_valid_o;
  logic rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic rsp_err_o;
  modport master (
    input req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, alu_res_i, rsp_ready_i,
    output req_ready_o, alu_a_o, alu_b_o, alu_op_o, rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o
  );
  modport slave (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, alu_res_i, rsp_ready_i,
    input req_ready_o, alu_a_o, alu_b_o, alu_op_o, rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o
  );
endinterface

// File: rtl/alu_op_issuer_fifo.sv
// alu_req_fifo: synchronous request FIFO, power-of-two depth, wrapping pointers
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input logic clk_i,
  input logic rst_ni,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // storage needs no reset; only the pointers define validity
  always_ff @(posedge clk_i)
    if (push) mem[wp] <= din;
  // pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: queues ALU requests, issues them one at a time, returns results in order (stats via ALU_ISSUE_STATS_EN)
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic clk_i,
  input logic rst_ni,
  alu_op_issuer_if.master bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0] stat_ops_o,
  output logic [15:0] stat_err_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = TAG_W + 5 + 64;
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic full, empty, push, pop, rsp_hs;
  logic [AW:0] count;
  logic [DW-1:0] head;
  logic [TAG_W-1:0] h_tag;
  alu_op_t h_op;
  logic [31:0] h_a, h_b;
  assign {h_tag, h_op, h_a, h_b} = head;
  assign bus.req_ready_o = count != (AW+1)'(FIFO_DEPTH);
  assign push = bus.req_valid_i && !full;
  assign rsp_hs = state == RESP && bus.rsp_ready_i;
  assign pop = !empty && (state == IDLE || rsp_hs);
  assign bus.rsp_valid_o = state == RESP;
  alu_req_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push(push),
    .pop(pop),
    .din({bus.req_tag_i, bus.req_op_i, bus.req_a_i, bus.req_b_i}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // issue FSM: illegal ops skip the ALU and go straight to an error response
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      bus.alu_a_o <= '0;
      bus.alu_b_o <= '0;
      bus.alu_op_o <= OP_ADD;
      bus.rsp_data_o <= '0;
      bus.rsp_tag_o <= '0;
      bus.rsp_err_o <= 1'b0;
    end else if (pop) begin
      bus.rsp_tag_o <= h_tag;
      if (is_legal_op(h_op)) begin
        bus.alu_a_o <= h_a;
        bus.alu_b_o <= h_b;
        bus.alu_op_o <= h_op;
        bus.rsp_err_o <= 1'b0;
        state <= EXEC;
      end else begin
        bus.rsp_err_o <= 1'b1;
        bus.rsp_data_o <= '0;
        state <= RESP;
      end
    end else if (state == EXEC) begin
      bus.rsp_data_o <= bus.alu_res_i;
      state <= RESP;
    end else if (rsp_hs) begin
      state <= IDLE;
    end
`ifdef ALU_ISSUE_STATS_EN
  // completed-op counters; the error count saturates, the op count wraps
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      stat_ops_o <= '0;
      stat_err_o <= '0;
    end else if (rsp_hs) begin
      stat_ops_o <= bus.rsp_err_o ? stat_ops_o : stat_ops_o + 32'd1;
      stat_err_o <= bus.rsp_err_o && stat_err_o != 16'hFFFF ? stat_err_o + 16'd1 : stat_err_o;
    end
`endif
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed and random stimulus checked against an in-order response model
module tb_alu_op_issuer;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;
  alu_op_issuer_if #(.TAG_W(4)) bus ();
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_err;
`endif
  alu_op_issuer #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .bus(bus)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops_o(stat_ops),
    .stat_err_o(stat_err)
`endif
  );
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a << b[4:0];
      5'd3: return $signed(a) >>> b[4:0];
      5'd4: return a & b;
      5'd5: return a | b;
      5'd6: return a ^ b;
      5'd7: return {31'b0, a == b};
      5'd8: return {31'b0, $signed(a) <= $signed(b)};
      5'd9: return {31'b0, $signed(a) >= $signed(b)};
      5'd10: return {31'b0, a != b};
      5'd31: return a + 32'd4;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  assign bus.alu_res_i = alu_f(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);
  function automatic logic legal(input logic [4:0] op);
    return op < 5'd11 || op == 5'd31;
  endfunction
  typedef struct {
    logic [3:0] tag;
    logic [31:0] data;
    logic err;
  } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, cycle = 0, last_hs = 0, prev_hs = 0, n_ops = 0, n_err = 0;
  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag, input logic rr);
    exp_t e;
    @(negedge clk);
    bus.req_valid_i = v;
    bus.req_op_i = op;
    bus.req_a_i = a;
    bus.req_b_i = b;
    bus.req_tag_i = tag;
    bus.rsp_ready_i = rr;
    #1;
    if (bus.rsp_valid_o && rr) begin
      if (exp_q.size() == 0) chk("stale_rsp", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", bus.rsp_data_o, e.data);
        chk("rsp_tag", 32'(bus.rsp_tag_o), 32'(e.tag));
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
        if (e.err) n_err++;
        else n_ops++;
        prev_hs = last_hs;
        last_hs = cycle;
      end
    end
    if (v && bus.req_ready_o) begin
      e.tag = tag;
      e.err = !legal(op);
      e.data = legal(op) ? alu_f(op, a, b) : 32'd0;
      exp_q.push_back(e);
    end
    cycle++;
  endtask
  task automatic idle(input logic rr);
    cyc(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, rr);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle(1'b1);
    chk("drain_empty", 32'(exp_q.size()), 0);
    idle(1'b1);
  endtask
  task automatic chk_reset_vals();
    chk("rst_req_ready", 32'(bus.req_ready_o), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    chk("rst_rsp_data", bus.rsp_data_o, 0);
    chk("rst_rsp_tag", 32'(bus.rsp_tag_o), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err_o), 0);
    chk("rst_alu_a", bus.alu_a_o, 0);
    chk("rst_alu_b", bus.alu_b_o, 0);
    chk("rst_alu_op", 32'(bus.alu_op_o), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [4:0] op;
    bus.req_valid_i = 0;
    bus.req_op_i = 0;
    bus.req_a_i = 0;
    bus.req_b_i = 0;
    bus.req_tag_i = 0;
    bus.rsp_ready_i = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_ni = 1'b1;
    cyc(1'b1, 5'd0, 32'd5, 32'd3, 4'd2, 1'b0);
    idle(1'b0);
    chk("lat_n1", 32'(bus.rsp_valid_o), 0);
    idle(1'b0);
    chk("lat_n2", 32'(bus.rsp_valid_o), 0);
    idle(1'b0);
    chk("lat_n3", 32'(bus.rsp_valid_o), 1);
    chk("add_data", bus.rsp_data_o, 32'd8);
    drain();
    cyc(1'b1, 5'd1, 32'd10, 32'd4, 4'd1, 1'b1);
    cyc(1'b1, 5'd2, 32'd1, 32'd3, 4'd2, 1'b1);
    drain();
    chk("b2b_spacing", 32'(last_hs - prev_hs), 2);
    cyc(1'b1, 5'd15, 32'd9, 32'd9, 4'd7, 1'b1);
    cyc(1'b1, 5'd6, 32'hF0, 32'hFF, 4'd8, 1'b1);
    drain();
    for (int t = 0; t < 5; t++) cyc(1'b1, 5'd0, 32'(t), 32'd100, 4'(t), 1'b0);
    idle(1'b0);
    chk("full_ready", 32'(bus.req_ready_o), 0);
    cyc(1'b1, 5'd0, 32'd1, 32'd1, 4'd9, 1'b0);
    drain();
    cyc(1'b1, 5'd0, 32'd7, 32'd7, 4'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals();
    exp_q.delete();
    n_ops = 0;
    n_err = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (6) idle(1'b1);
    chk("post_rst_valid", 32'(bus.rsp_valid_o), 0);
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 3) == 0 ? 5'($urandom_range(11, 30)) : ($urandom_range(0, 11) == 11 ? 5'd31 : 5'($urandom_range(0, 10)));
      cyc(1'($urandom_range(0, 1)), op, $urandom, $urandom, 4'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();
`ifdef ALU_ISSUE_STATS_EN
    chk("stat_ops", stat_ops, n_ops);
    chk("stat_err", 32'(stat_err), n_err);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Initiator side of the ALU operand/opcode interface. It drives a_i/b_i/op_i (5-bit op type) into a combinational ALU and samples the ALU's 32-bit result.
- Upstream requests (op, operands, tag) are buffered in a small FIFO and issued one at a time.
- Opcodes outside the legal set are rejected with an error response.
- Results return on a valid/ready response channel.

Parameters:
- FIFO_DEPTH, 4: request queue entries; power of 2, ≥2.
- TAG_W, 4: width of the request tag echoed on the response.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  FIFO not full
- req_op_i  in  5  ALU op code (alu_op_t)
- req_a_i  in  32  operand A
- req_b_i  in  32  operand B
- req_tag_i  in  TAG_W  request tag
- alu_a_o  out  32  to ALU a_i
- alu_b_o  out  32  to ALU b_i
- alu_op_o  out  5  to ALU op_i
- alu_res_i  in  32  from ALU alu_o
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_data_o  out  32  captured result (0 on error)
- rsp_tag_o  out  TAG_W  echoed tag
- rsp_err_o  out  1  illegal opcode

Behaviour:
- Reset: async on rst_ni low. FIFO empty, FSM IDLE. All outputs 0 except req_ready_o=1: alu_a_o=0, alu_b_o=0, alu_op_o=0 (ADD), rsp_valid_o=0, rsp_data_o=0, rsp_tag_o=0, rsp_err_o=0.
- Reset mid-operation discards the queue and any pending response; no response is emitted for it.
- Legal ops: ADD=0, SUB=1, SLL=2, SRA=3, AND=4, OR=5, XOR=6, EQL=7, LESSEQL=8, GREQL=9, NEQL=10, JAL_JALR=31. Codes 11..30 are illegal.
- Request handshake:
  - Push on req_valid_i && req_ready_o.
  - req_ready_o = !full, combinational from the count only.
  - A push and a pop in the same cycle while full is not accepted: ready is already low.
  - Simultaneous push and pop in any non-full state keeps the count unchanged.
- FSM:
  - IDLE: if FIFO not empty, pop the head and register it into alu_a_o/alu_b_o/alu_op_o plus the tag. Legal op → EXEC. Illegal op → RESP with rsp_err_o=1 and rsp_data_o=0; the ALU outputs keep their previous values.
  - EXEC: one cycle. The ALU inputs are stable, and alu_res_i is sampled into rsp_data_o at the end of the cycle → RESP.
  - RESP: rsp_valid_o=1. rsp_data/tag/err are held stable until rsp_ready_i. On the handshake: if FIFO not empty, pop the next entry directly (→ EXEC or the illegal path); else → IDLE.
- Latency: a push into an empty FIFO at cycle N gives pop/issue at N+1, EXEC at N+2, and rsp_valid_o at N+3.
  - Steady-state throughput with rsp_ready_i=1 is one op per 2 cycles (legal) or one per cycle (illegal).
  - Responses return strictly in request order.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- Backpressure: while rsp_ready_i=0 the block holds RESP and the FIFO may fill. req_ready_o drops exactly when count==FIFO_DEPTH.

Optional Feature:
- ALU_ISSUE_STATS_EN defined: adds output ports stat_ops_o (32) and stat_err_o (16).
  - stat_ops_o increments on every legal RESP handshake.
  - stat_err_o increments on every illegal RESP handshake; it saturates at 16'hFFFF.
  - stat_ops_o wraps.
  - Both reset to 0.
- Undefined: those ports and counters do not exist; the behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_op_t (logic [4:0]);
  - the op constants OP_ADD..OP_JAL_JALR;
  - the function is_legal_op(alu_op_t).
- Sub-module alu_req_fifo holds the parameterised sync FIFO: push, pop, full, empty, count, data = {tag, op, a, b}.

Test Plan:
- Single ADD: op=0, a=5, b=3, tag=2, connected to the ALU → rsp_valid_o at N+3, data=8, tag=2, err=0.
- Back-to-back SUB (a=10, b=4) then SLL (a=1, b=3), rsp_ready_i=1 → responses 6 then 8, in order, 2 cycles apart.
- Illegal op=15, tag=7 → rsp_err_o=1, data=0, tag=7. The next legal XOR (a=0xF0, b=0xFF) → 0x0F.
- Backpressure: hold rsp_ready_i=0 and push 5 requests with depth 4 → first pops, 4 queue, req_ready_o=0. Release → all 5 responses in tag order 0..4.
- Reset asserted during EXEC → all outputs at reset values immediately, req_ready_o=1, no stale response after release.
- With ALU_ISSUE_STATS_EN: 3 legal + 2 illegal ops completed → stat_ops_o=3, stat_err_o=2.
